seg7_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-select 7-segment display driven by TOP. It holds a double-buffered 4-digit hex value and decimal-point mask, and sequences digit selects one slot at a time. Each slot has an anti-ghosting blanking gap and 16-step PWM brightness. New data is applied only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg7_scan_controller.sv | 201 ++++++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit common-select 7-segment display.
// Each digit slot is a dark blanking gap followed by 16 PWM steps. Display data is
// double-buffered and only swapped at frame boundaries or while idle.
module seg7_scan_controller #(
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned STEP_CYCLES  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_load,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_dp,
  input  logic        i_lzb,
  input  logic [3:0]  i_brightness,
  output logic [7:0]  o_LED,
  output logic [3:0]  o_digitSelect,
  output logic        o_frame_done
);

  localparam int unsigned SlotCycles = BLANK_CYCLES + 16 * STEP_CYCLES;
  localparam int unsigned CntW       = $clog2(SlotCycles + 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] StepLen   = CntW'(STEP_CYCLES);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [1:0] {StIdle, StBlank, StOn, StOff} state_e;

  state_e          state_q, state_d;
  logic [1:0]      digit_q, digit_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bright_q, bright_d;

  logic [15:0] pend_digits_q, disp_digits_q;
  logic [3:0]  pend_dp_q, disp_dp_q;
  logic        pend_valid_q;

  logic [7:0] led_q, led_d;
  logic [3:0] sel_q, sel_d;
  logic       frame_done_q, frame_done_d;

  logic       apply;
  logic [3:0] lz_blank;
  logic [3:0] nibble;

  // Last counter value of the lit and dark PWM phases for a given brightness.
  function automatic logic [CntW-1:0] on_last(input logic [3:0] b);
    return CntW'(b) * StepLen - CntOne;
  endfunction

  function automatic logic [CntW-1:0] off_last(input logic [3:0] b);
    return (CntW'(5'd16) - CntW'(b)) * StepLen - CntOne;
  endfunction

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Slot sequencing: next state, counter, digit index and latched brightness.
  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    cnt_d    = cnt_q + CntOne;
    bright_d = bright_q;
    if (!i_enable) begin
      state_d = StIdle;
      digit_d = 2'd0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          digit_d = 2'd0;
          cnt_d   = '0;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            bright_d = i_brightness;
            state_d  = (i_brightness != 4'd0) ? StOn : StOff;
            cnt_d    = '0;
          end
        end
        StOn: begin
          if (cnt_q == on_last(bright_q)) begin
            state_d = StOff;
            cnt_d   = '0;
          end
        end
        StOff: begin
          if (cnt_q == off_last(bright_q)) begin
            state_d = StBlank;
            digit_d = digit_q + 2'd1;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A digit is blank when it and every more significant nibble are zero; digit 0 never is.
  always_comb begin
    lz_blank[3] = (disp_digits_q[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (disp_digits_q[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (disp_digits_q[7:4] == 4'h0);
    lz_blank[0] = 1'b0;
  end

  // Output values for the upcoming cycle, registered alongside the state.
  always_comb begin
    sel_d        = 4'b0000;
    led_d        = 8'h00;
    nibble       = disp_digits_q[{digit_d, 2'b00} +: 4];
    frame_done_d = (state_d == StOff) && (digit_d == 2'd3) && (cnt_d == off_last(bright_d));
    if (state_d == StOn) begin
      sel_d    = 4'b0001 << digit_d;
      led_d[7] = disp_dp_q[digit_d];
      if (!(i_lzb && lz_blank[digit_d])) begin
        led_d[6:0] = hex_seg(nibble);
      end
    end
  end

  // Display data may only change between frames or while the scan is idle.
  assign apply = frame_done_q || (state_q == StIdle);

  // Scan state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      digit_q  <= 2'd0;
      cnt_q    <= '0;
      bright_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      cnt_q    <= cnt_d;
      bright_q <= bright_d;
    end
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      led_q        <= 8'h00;
      sel_q        <= 4'b0000;
      frame_done_q <= 1'b0;
    end else begin
      led_q        <= led_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Double buffer: a load on an apply cycle bypasses the pending buffer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_digits_q <= 16'h0000;
      pend_dp_q     <= 4'h0;
      pend_valid_q  <= 1'b0;
      disp_digits_q <= 16'h0000;
      disp_dp_q     <= 4'h0;
    end else if (i_load && apply) begin
      disp_digits_q <= i_digits;
      disp_dp_q     <= i_dp;
      pend_valid_q  <= 1'b0;
    end else if (i_load) begin
      pend_digits_q <= i_digits;
      pend_dp_q     <= i_dp;
      pend_valid_q  <= 1'b1;
    end else if (apply && pend_valid_q) begin
      disp_digits_q <= pend_digits_q;
      disp_dp_q     <= pend_dp_q;
      pend_valid_q  <= 1'b0;
    end
  end

  assign o_LED         = led_q;
  assign o_digitSelect = sel_q;
  assign o_frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller. Every cycle of interest has an expected
// {select, LED, frame_done} word queued up front and compared one cycle at a time.
module tb_seg7_scan_controller;

  localparam int unsigned Blank = 2;
  localparam int unsigned Step  = 4;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_enable;
  logic        i_load;
  logic [15:0] i_digits;
  logic [3:0]  i_dp;
  logic        i_lzb;
  logic [3:0]  i_brightness;
  logic [7:0]  o_LED;
  logic [3:0]  o_digitSelect;
  logic        o_frame_done;

  logic [12:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  string       tag   = "init";

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_controller #(
    .BLANK_CYCLES(Blank),
    .STEP_CYCLES (Step)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_enable     (i_enable),
    .i_load       (i_load),
    .i_digits     (i_digits),
    .i_dp         (i_dp),
    .i_lzb        (i_lzb),
    .i_brightness (i_brightness),
    .o_LED        (o_LED),
    .o_digitSelect(o_digitSelect),
    .o_frame_done (o_frame_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] exp_led(input logic [15:0] val, input logic [3:0] dp,
                                         input bit lzb, input int d);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = val >> (4 * d);
    nib   = upper[3:0];
    if (lzb && d != 0 && upper == 16'h0000) return {dp[d], 7'h00};
    return {dp[d], seg_tab[nib]};
  endfunction

  task automatic push_slot(input int d, input logic [7:0] led, input int b);
    logic [3:0] sel;
    logic       fd;
    sel = 4'b0001 << d;
    for (int i = 0; i < Blank; i++) exp_q.push_back(13'h0000);
    for (int i = 0; i < b * Step; i++) exp_q.push_back({sel, led, 1'b0});
    for (int i = 0; i < (16 - b) * Step; i++) begin
      fd = (d == 3) && (i == (16 - b) * Step - 1);
      exp_q.push_back({4'b0000, 8'h00, fd});
    end
  endtask

  task automatic push_frame(input logic [15:0] val, input logic [3:0] dp, input bit lzb,
                            input int b_first, input int b_rest);
    for (int d = 0; d < 4; d++) push_slot(d, exp_led(val, dp, lzb, d), (d == 0) ? b_first : b_rest);
  endtask

  task automatic check(input string name, input logic [12:0] obs, input logic [12:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d: got sel=%b led=%h fd=%b, want sel=%b led=%h fd=%b", name, cyc,
             obs[12:9], obs[8:1], obs[0], exp[12:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic tick_check();
    logic [12:0] exp;
    @(posedge i_clk);
    #1;
    cyc++;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s cyc=%0d: no expected entry queued", tag, cyc);
    end else begin
      exp = exp_q.pop_front();
      check(tag, {o_digitSelect, o_LED, o_frame_done}, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) tick_check();
  endtask

  initial begin
    i_rst_n = 1'b0; i_enable = 1'b0; i_load = 1'b0; i_digits = 16'h0;
    i_dp = 4'h0; i_lzb = 1'b0; i_brightness = 4'd0;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset", {o_digitSelect, o_LED, o_frame_done}, 13'h0000);

    // Load while idle goes straight to display; first frame at full brightness.
    tag = "f1_12a0_b15";
    i_enable = 1'b1; i_load = 1'b1; i_digits = 16'h12A0; i_dp = 4'b0010;
    i_brightness = 4'd15; i_rst_n = 1'b1;
    push_frame(16'h12A0, 4'b0010, 1'b0, 15, 15);
    tick_check();
    i_load = 1'b0;
    tick_n(263);

    tag = "f2_b0";
    i_brightness = 4'd0;
    push_frame(16'h12A0, 4'b0010, 1'b0, 0, 0);
    tick_n(264);

    // Slot 0 at B=8; B changed to 3 mid-slot takes effect from slot 1. Load 1234 pending.
    tag = "f3_b8_b3";
    i_brightness = 4'd8;
    push_frame(16'h12A0, 4'b0010, 1'b0, 8, 3);
    tick_check();
    i_load = 1'b1; i_digits = 16'h1234; i_dp = 4'b0000;
    tick_check();
    i_load = 1'b0;
    tick_n(9);
    i_brightness = 4'd3;
    tick_n(253);

    // Load of zeros during digit 1 must not disturb the rest of this frame.
    tag = "f4_1234";
    i_brightness = 4'd15;
    push_frame(16'h1234, 4'b0000, 1'b0, 15, 15);
    tick_n(76);
    i_load = 1'b1; i_digits = 16'h0000; i_dp = 4'b0000;
    tick_check();
    i_load = 1'b0;
    tick_n(187);

    tag = "f5_zero";
    push_frame(16'h0000, 4'b0000, 1'b0, 15, 15);
    tick_n(263);
    // This load lands on the frame_done cycle and applies to the very next frame.
    tag = "f5_last";
    i_load = 1'b1; i_digits = 16'h0070; i_dp = 4'b0000; i_lzb = 1'b1;
    tick_n(1);

    tag = "f6_lzb_0070";
    push_frame(16'h0070, 4'b0000, 1'b1, 15, 15);
    tick_check();
    i_load = 1'b0;
    tick_n(99);
    i_load = 1'b1; i_digits = 16'h0000; i_dp = 4'b1000;
    tick_check();
    i_load = 1'b0;
    tick_n(163);

    tag = "f7_lzb_0000";
    push_frame(16'h0000, 4'b1000, 1'b1, 15, 15);
    tick_n(264);

    // Run into digit 2 ON, then disable for 5 cycles while loading BEEF.
    tag = "f8_partial";
    for (int d = 0; d < 3; d++) push_slot(d, exp_led(16'h0000, 4'b1000, 1'b1, d), 15);
    repeat (56) void'(exp_q.pop_back());
    tick_n(142);
    tag = "disabled";
    i_enable = 1'b0; i_load = 1'b1; i_digits = 16'hBEEF; i_dp = 4'b0001;
    repeat (5) exp_q.push_back(13'h0000);
    tick_check();
    i_load = 1'b0;
    tick_n(4);
    i_enable = 1'b1;

    tag = "f9_beef";
    push_frame(16'hBEEF, 4'b0001, 1'b1, 15, 15);
    tick_n(264);

    tag = "f10_partial";
    for (int d = 0; d < 3; d++) push_slot(d, exp_led(16'hBEEF, 4'b0001, 1'b1, d), 15);
    repeat (56) void'(exp_q.pop_back());
    tick_n(142);
    i_rst_n = 1'b0;
    #1;
    check("async_reset", {o_digitSelect, o_LED, o_frame_done}, 13'h0000);
    @(posedge i_clk);
    #1;
    check("held_reset", {o_digitSelect, o_LED, o_frame_done}, 13'h0000);
    i_rst_n = 1'b1;

    tag = "f11_after_reset";
    push_frame(16'h0000, 4'b0000, 1'b1, 15, 15);
    tick_n(264);

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL queue_drained: got %0d entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
